router_read_scheduler: RTL
==========================

Name: router_read_scheduler

Overview:
- Output-side scheduler for the 1x3 router.
- Watches the three destination FIFOs (vld_out_x / data_out_x) and drives their read_enb_x.
- Drains whole packets, one port at a time, under round-robin arbitration onto a single merged stream with sop/eop/port tags.
- Replaces three independent external readers; consumers see one packet-atomic, backpressured stream.

Parameters:
- DATA_WIDTH, 8, byte width of FIFO data and merged output.
- STALL_LIMIT, 30, consecutive cycles of vld_out_g low mid-packet (sink ready) before the packet is aborted.
- CNT_WIDTH, 7, width of remaining-byte counter (holds 63+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- vld_out_0/1/2  in  1  FIFO x non-empty.
- data_out_0/1/2  in  DATA_WIDTH  FIFO x read data; valid the cycle after read_enb_x sampled high with vld_out_x high.
- sink_ready  in  1  sink can accept a beat in the next cycle (credit-style).
- read_enb_0/1/2  out  1  FIFO read strobes; at most one high per cycle.
- m_data  out  DATA_WIDTH  merged output byte.
- m_valid  out  1  m_data valid this cycle; not backpressurable once asserted.
- m_sop  out  1  beat is a header.
- m_eop  out  1  beat is parity (last byte).
- m_port  out  2  source port of current packet.
- abort  out  1  one-cycle pulse when a packet is abandoned on stall.
- busy_rd  out  1  state != IDLE.

Behaviour:
Reset values (asynchronous, immediate on reset high):
- state=IDLE, rr_last=2 (port 0 wins first), rem=0, pend=0, stall_cnt=0.
- All outputs 0.
- Reset mid-packet abandons it; unread bytes stay in the FIFO.

FSM:
- IDLE:
  - If sink_ready and any vld_out_x: grant g = first set port in order rr_last+1, rr_last+2, rr_last (mod 3).
  - Assert read_enb_g combinationally this cycle; latch g into m_port and rr_last; go HDR.
- HDR (exactly 1 cycle):
  - m_valid=1, m_sop=1, m_data=data_out_g.
  - rem <= data_out_g[7:2] + 1 (payload plus parity).
  - Length 0 → rem=1 (header+parity only).
  - No read issued; go BODY.
- BODY:
  - read_enb_g = (rem!=0) && vld_out_g && sink_ready.
  - On issue: rem decrements and pend <= 1; otherwise pend <= 0.
  - When pend=1: m_valid=1, m_data=data_out_g, m_sop=0.
  - When pend=1 and rem==0: m_eop=1; next state IDLE.
- Stall counter:
  - In BODY with rem!=0, sink_ready=1 and vld_out_g=0: stall_cnt increments.
  - Any issue, or sink_ready=0, clears it.
  - When stall_cnt reaches STALL_LIMIT-1 and stalls again: abort=1 that cycle; next state IDLE, with no m_eop.
  - rr_last keeps the aborted port.

Throughput and latency:
- read_enb to m_valid: 1 cycle.
- Body streams one byte per cycle; one bubble after the header.
- Back-to-back packets: the eop cycle is followed by IDLE, so minimum 1 cycle between packets.

Rules:
- Never more than one read_enb high.
- Never read a FIFO whose vld_out is low.
- Ports other than g are ignored while busy, even if their vld_out stays high.
- sink_ready low blocks new grants and issues only; a beat already pending is still presented.
- Starvation bound: a waiting port is granted within 2 packets.

Test Plan:
1. Port 1 holds 0x0D, 0xA1, 0xA2, 0xA3, parity; sink_ready=1 → read_enb_1 high 5 cycles total (1 in IDLE, 4 in BODY). Beats: 0x0D with sop, then A1, A2, A3, then parity with eop. m_port=1; read_enb_0/2 never high.
2. After reset, all three FIFOs each hold a 1-byte-payload packet → grant order 0,1,2. Refill port 0 → next grant 0. Each packet is 3 beats, packets are never interleaved, and busy_rd drops for exactly 1 cycle between packets.
3. sink_ready low for 4 cycles after the 2nd payload issue → no read_enb during the stall, pending byte still emitted once. Sequence resumes intact, abort=0, stall_cnt stays 0.
4. Port 2 packet with length 5, FIFO empties after 2 payload bytes, sink_ready=1 → abort pulses after 30 low-vld cycles. busy_rd=0 next cycle, no eop; next grant goes to port 0 if pending.
5. Header 0x00 on port 0 → exactly 2 beats (sop 0x00, eop parity), rem never underflows.
6. reset asserted in BODY mid-read → read_enb_x, m_valid, busy_rd go 0 in the same cycle. After release, the first grant goes to port 0.

Source files
------------

// File: rtl/router_read_scheduler.sv
// Drains the 1x3 router's destination FIFOs one whole packet at a time, round-robin, onto one tagged stream.
// Latency: read_enb to m_valid 1 cycle; one bubble after the header, then one byte per cycle.
// Backpressure: sink_ready low blocks new grants and reads only; a byte already read is still presented.
module router_read_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int STALL_LIMIT = 30,
    parameter int CNT_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_out_0,
    input  logic                  vld_out_1,
    input  logic                  vld_out_2,
    input  logic [DATA_WIDTH-1:0] data_out_0,
    input  logic [DATA_WIDTH-1:0] data_out_1,
    input  logic [DATA_WIDTH-1:0] data_out_2,
    input  logic                  sink_ready,
    output logic                  read_enb_0,
    output logic                  read_enb_1,
    output logic                  read_enb_2,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [1:0]            m_port,
    output logic                  abort,
    output logic                  busy_rd
);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

    state_t               state;
    logic [1:0]           rr_last;
    logic [CNT_WIDTH-1:0] rem;
    logic                 pend;
    logic [SW-1:0]        stall_cnt;

    logic [2:0]            vld_vec;
    logic                  vld_g;
    logic [DATA_WIDTH-1:0] data_g;
    logic [1:0]            p1, p2, grant_port;
    logic                  idle_grant, issue, stall, stall_hit, rd_vld;
    logic [1:0]            rd_port;

    assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};

    // m_port holds the granted port for the whole packet, so it also selects the data path
    always_comb begin
        vld_g  = 1'b0;
        data_g = '0;
        case (m_port)
            2'd0:    begin vld_g = vld_out_0; data_g = data_out_0; end
            2'd1:    begin vld_g = vld_out_1; data_g = data_out_1; end
            2'd2:    begin vld_g = vld_out_2; data_g = data_out_2; end
            default: begin vld_g = 1'b0;      data_g = '0;         end
        endcase
    end

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Priority rr_last+1, rr_last+2, rr_last: later assignments win
    always_comb begin
        p1         = next_port(rr_last);
        p2         = next_port(p1);
        grant_port = rr_last;
        if (vld_vec[p2]) grant_port = p2;
        if (vld_vec[p1]) grant_port = p1;
    end

    assign idle_grant = (state == IDLE) && sink_ready && (|vld_vec);
    assign issue      = (state == BODY) && (rem != '0) && vld_g && sink_ready;
    assign stall      = (state == BODY) && (rem != '0) && !vld_g && sink_ready;
    assign stall_hit  = stall && (stall_cnt == SW'(STALL_LIMIT - 1));

    // Strobes are gated by reset so a FIFO is never popped while the scheduler is held
    assign rd_vld     = !reset && (idle_grant || issue);
    assign rd_port    = (state == IDLE) ? grant_port : m_port;
    assign read_enb_0 = rd_vld && (rd_port == 2'd0);
    assign read_enb_1 = rd_vld && (rd_port == 2'd1);
    assign read_enb_2 = rd_vld && (rd_port == 2'd2);

    assign m_valid = (state == HDR) || ((state == BODY) && pend);
    assign m_sop   = (state == HDR);
    assign m_eop   = (state == BODY) && pend && (rem == '0);
    assign m_data  = m_valid ? data_g : '0;
    assign abort   = stall_hit;
    assign busy_rd = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_last   <= 2'd2;
            rem       <= '0;
            pend      <= 1'b0;
            stall_cnt <= '0;
            m_port    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    pend      <= 1'b0;
                    stall_cnt <= '0;
                    if (idle_grant) begin
                        m_port  <= grant_port;
                        rr_last <= grant_port;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    // Header carries payload length in its upper bits; +1 covers the parity byte
                    rem   <= CNT_WIDTH'(data_g[DATA_WIDTH-1:2]) + CNT_WIDTH'(1);
                    pend  <= 1'b0;
                    state <= BODY;
                end
                BODY: begin
                    pend <= issue;
                    if (issue) rem <= rem - CNT_WIDTH'(1);
                    if (stall && !stall_hit) stall_cnt <= stall_cnt + SW'(1);
                    else                     stall_cnt <= '0;
                    if ((pend && (rem == '0)) || stall_hit) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
